// File: rtl/microcode_sequencer.sv
// Microcode sequencer: walks {opcode, step} through the microcode ROM,
// latches the IR opcode, and gates the ROM control word to the datapath.
module microcode_sequencer #(
  parameter int         END_BIT     = 5,
  parameter logic [7:0] LATCH_STEP  = 8'd2,
  parameter logic [7:0] HALT_OPCODE = 8'hFF,
  parameter logic [7:0] MAX_STEP    = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ir_opcode_in,
  input  logic        hold,
  input  logic [31:0] ctrl_word_in,
  output logic [15:0] instr_mem_addr_out,
  output logic [31:0] ctrl_word_out,
  output logic        instr_done,
  output logic        illegal,
  output logic        halted,
  output logic [15:0] instr_count
);

  typedef enum logic [0:0] {
    S_RUN,
    S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [7:0]  step_q, step_d;
  logic [15:0] count_q, count_d;
  logic        done_q, done_d;
  logic        ill_q, ill_d;

  logic        word_zero;
  logic        end_bit;
  logic        at_max;
  logic        at_latch;
  logic        halt_op;

  assign word_zero = (ctrl_word_in == 32'h0);
  assign end_bit   = ctrl_word_in[END_BIT];
  assign at_max    = (step_q == MAX_STEP);
  assign at_latch  = (step_q == LATCH_STEP);
  assign halt_op   = (ir_opcode_in == HALT_OPCODE);

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    step_d   = step_q;
    count_d  = count_q;
    done_d   = 1'b0;
    ill_d    = 1'b0;
    unique case (state_q)
      S_HALT: begin
        step_d = 8'h00;
      end
      S_RUN: begin
        if (hold) begin
          step_d = step_q;
        end else if (word_zero) begin
          step_d = 8'h00;
          ill_d  = 1'b1;
        end else if (end_bit) begin
          step_d  = 8'h00;
          count_d = count_q + 16'd1;
          done_d  = 1'b1;
        end else if (at_max) begin
          // never wrap silently past the last legal step
          step_d = 8'h00;
          ill_d  = 1'b1;
        end else if (at_latch) begin
          opcode_d = ir_opcode_in;
          if (halt_op) begin
            state_d = S_HALT;
            step_d  = 8'h00;
          end else begin
            step_d = step_q + 8'd1;
          end
        end else begin
          step_d = step_q + 8'd1;
        end
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_RUN;
      opcode_q <= 8'h00;
      step_q   <= 8'h00;
      count_q  <= 16'h0000;
      done_q   <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      step_q   <= step_d;
      count_q  <= count_d;
      done_q   <= done_d;
      ill_q    <= ill_d;
    end
  end

  // stall and halt must not leak side effects into the datapath
  assign ctrl_word_out      = (state_q == S_RUN && !hold) ? ctrl_word_in
                                                          : 32'h0;
  assign instr_mem_addr_out = {opcode_q, step_q};
  assign instr_done         = done_q;
  assign illegal            = ill_q;
  assign halted             = (state_q == S_HALT);
  assign instr_count        = count_q;

endmodule
